crc_frame_ctrl: RTL
===================

# crc_frame_ctrl

Byte-serial sequencer for the CRC datapath: accepts a framed byte stream over a valid/ready handshake, drives a bit-serial CRC-8 engine one bit per cycle (MSB first), and presents the finalised CRC for each frame on a valid/ready output. It sits between the pin-level input logic and the result output of the CRC calculator tile. It owns all frame sequencing, back-pressure and CRC register initialisation.

## Interface
Parameters:
- POLY, 8'h07, generator polynomial without the implicit x^8 term
- INIT, 8'h00, CRC register value at frame start
- XOROUT, 8'h00, value XORed into the register to form the result

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low freezes all state
- in_valid  in  1  in_data/in_last are valid
- in_data  in  8  message byte, processed MSB first
- in_last  in  1  byte is the final byte of the frame
- in_ready  out  1  controller can accept a byte
- out_valid  out  1  out_crc holds a finished frame CRC
- out_crc  out  8  final CRC (register ^ XOROUT)
- out_ready  in  1  consumer accepts out_crc
- busy  out  1  frame in progress (any state except IDLE)

## Operation
- States: IDLE, ACCEPT, SHIFT, DONE.
- IDLE: crc = INIT; in_ready = 1. Accept (in_valid & in_ready & ena): latch in_data into shift reg, latch in_last, bit_cnt = 7, go SHIFT.
- ACCEPT: as IDLE, but crc retains its value (mid-frame).
- SHIFT: each enabled cycle, fb = crc[7] ^ sh[7]; crc = {crc[6:0],1'b0} ^ (fb ? POLY : 0); sh <<= 1; bit_cnt -= 1. On the cycle bit_cnt == 0: go DONE if latched last, else ACCEPT. in_ready = 0.
- DONE: out_valid = 1, out_crc = crc ^ XOROUT, registered and stable until taken. On out_valid & out_ready & ena: go IDLE (crc reloaded to INIT). in_ready = 0.
- ena = 0: no state, counter or register change; in_ready and out_valid forced 0 so no handshake completes.
- Empty frames cannot occur: a frame is ≥1 byte; in_last on the first byte yields a 1-byte frame.
- in_valid while in_ready = 0 is held by the sender (standard valid/ready); in_data must not change while in_valid is high and unaccepted. The controller ignores it.
- All arithmetic is 8-bit; bit_cnt is 3 bits and does not wrap beyond 0 (the exit happens at 0).

## Timing
- Reset (async assert, sync-to-clk release via top level): state IDLE, crc = INIT, in_ready = 1, out_valid = 0, out_crc = 0, busy = 0.
- Byte accepted at cycle T: SHIFT in T+1..T+8; in_ready high again at T+9 (mid-frame) or out_valid high at T+9 (last byte).
- Throughput: one byte per 9 enabled cycles; frame of N bytes → out_valid 9N cycles after the first accept, assuming no stalls.
- out_valid high with out_ready high in the same cycle: consumed; next cycle IDLE, in_ready = 1.
- rst_n asserted mid-SHIFT or in DONE: immediate return to reset values; partial frame discarded, pending result lost.

## Structure
- crc_pkg: state enum (IDLE/ACCEPT/SHIFT/DONE), default CRC-8 constants (POLY 8'h07, INIT 8'h00, XOROUT 8'h00).
- Sub-module crc8_bit_step: combinational one-bit update (crc, data bit, POLY) → next crc; instantiated once in SHIFT datapath.
- Controller: FSM + bit counter + shift reg + crc reg + output register.

## Test plan
- Single byte 8'h01, in_last = 1 → out_valid at T+9, out_crc = 8'h07; busy low after out_ready.
- Single byte 8'hFF, in_last = 1 → out_crc = 8'hF3; single byte 8'h00 → 8'h00.
- Frame "123456789" (8'h31..8'h39, last on 8'h39), in_valid always high → out_crc = 8'hF4 after 81 cycles; in_ready pulses once per 9 cycles.
- Back-pressure: out_ready low 20 cycles after a result → out_valid/out_crc stable, in_ready = 0 throughout; next frame's first byte accepted only after consume.
- ena toggled low 3 cycles during SHIFT of "123456789" → result still 8'hF4, completion delayed exactly 3 cycles.
- rst_n pulsed low at bit 4 of the 2nd byte → outputs at reset values immediately; a following frame 8'h01 gives 8'h07 (no residue).

Source files
------------

// File: rtl/crc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | crc_pkg : shared FSM state encoding and default CRC-8 constants     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [7:0] C_CRC8_POLY   = 8'h07;
   localparam logic [7:0] C_CRC8_INIT   = 8'h00;
   localparam logic [7:0] C_CRC8_XOROUT = 8'h00;

endpackage
`default_nettype wire

// File: rtl/crc8_bit_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | crc8_bit_step : one-bit combinational CRC-8 update, MSB first       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module crc8_bit_step #(
   parameter logic [7:0] POLY = 8'h07
) (
   input  logic [7:0] crc_i,
   input  logic       bit_i,
   output logic [7:0] crc_o
);

   logic w_fb;

   assign w_fb  = crc_i[7] ^ bit_i;
   assign crc_o = {crc_i[6:0], 1'b0} ^ (w_fb ? POLY : 8'h00);

endmodule
`default_nettype wire

// File: rtl/crc_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | crc_frame_ctrl : byte-serial frame sequencer for a bit-serial CRC-8 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module crc_frame_ctrl
   import crc_pkg::*;
#(
   parameter logic [7:0] POLY   = C_CRC8_POLY,
   parameter logic [7:0] INIT   = C_CRC8_INIT,
   parameter logic [7:0] XOROUT = C_CRC8_XOROUT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_crc,
   input  logic       out_ready,
   output logic       busy
);

   state_e     state_q;
   logic [7:0] crc_q;
   logic [7:0] crc_d;
   logic [7:0] sh_q;
   logic [2:0] cnt_q;
   logic       last_q;
   logic [7:0] out_crc_q;

   crc8_bit_step #(
      .POLY (POLY)
   ) u_step (
      .crc_i (crc_q),
      .bit_i (sh_q[7]),
      .crc_o (crc_d)
   );

   // Handshakes are gated by ena so a frozen controller can never complete one.
   assign in_ready  = ena & ((state_q == ST_IDLE) | (state_q == ST_ACCEPT));
   assign out_valid = ena & (state_q == ST_DONE);
   assign out_crc   = out_crc_q;
   assign busy      = (state_q != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         crc_q     <= INIT;
         sh_q      <= 8'h00;
         cnt_q     <= 3'd0;
         last_q    <= 1'b0;
         out_crc_q <= 8'h00;
      end else if (ena) begin
         case (state_q)
            ST_IDLE: begin
               crc_q <= INIT;
               if (in_valid) begin
                  sh_q    <= in_data;
                  last_q  <= in_last;
                  cnt_q   <= 3'd7;
                  state_q <= ST_SHIFT;
               end
            end
            ST_ACCEPT: begin
               if (in_valid) begin
                  sh_q    <= in_data;
                  last_q  <= in_last;
                  cnt_q   <= 3'd7;
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               crc_q <= crc_d;
               sh_q  <= {sh_q[6:0], 1'b0};
               if (cnt_q == 3'd0) begin
                  if (last_q) begin
                     out_crc_q <= crc_d ^ XOROUT;
                     state_q   <= ST_DONE;
                  end else begin
                     state_q   <= ST_ACCEPT;
                  end
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  crc_q   <= INIT;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
